// File: rtl/thermo_spi_pkg.sv
// thermo_spi_pkg: state encoding and frame width shared by the thermocouple SPI front end and decoder.
package thermo_spi_pkg;
    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} spi_state_t;
    localparam int TC_FRAME_BITS = 32;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, resets to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/spi_rx_master.sv
// spi_rx_master: read-only SPI master clocking one frame out of the thermocouple converter.
module spi_rx_master
    import thermo_spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = TC_FRAME_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_ena,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 spi_not_busy,
    output logic [DATA_BITS-1:0] spi_rx_data,
    output logic                 rx_done
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    spi_state_t           state_q;
    logic [DW-1:0]        div_q, div_d;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q, rx_data_q;
    logic                 sclk_q, cs_n_q, nb_q, rx_done_q;
    logic                 miso_sync, div_end;
    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (miso),
        .q_o   (miso_sync)
    );
    assign div_end = (div_q == DW'(CLK_DIV - 1));
    assign div_d   = div_end ? '0 : div_q + 1'b1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            nb_q      <= 1'b1;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cs_n_q <= 1'b1;
                    sclk_q <= 1'b0;
                    div_q  <= '0;
                    if (spi_ena) begin
                        state_q <= CS_SETUP;
                        cs_n_q  <= 1'b0;
                        nb_q    <= 1'b0;
                        bit_q   <= '0;
                    end
                end
                CS_SETUP: begin
                    div_q <= div_d;
                    if (div_end) state_q <= SHIFT;
                end
                SHIFT: begin
                    div_q <= div_d;
                    if (div_end) begin
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            shift_q <= {shift_q[DATA_BITS-2:0], miso_sync};
                            bit_q   <= bit_q + 1'b1;
                        end else if (bit_q == BW'(DATA_BITS)) begin
                            // final falling edge doubles as CS_HOLD entry
                            state_q   <= CS_HOLD;
                            cs_n_q    <= 1'b1;
                            rx_data_q <= shift_q;
                            rx_done_q <= 1'b1;
                        end
                    end
                end
                CS_HOLD: begin
                    div_q <= div_d;
                    if (div_end) begin
                        state_q <= IDLE;
                        nb_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    nb_q    <= 1'b1;
                    div_q   <= '0;
                end
            endcase
        end
    end
    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign spi_not_busy = nb_q;
    assign spi_rx_data  = rx_data_q;
    assign rx_done      = rx_done_q;
endmodule

// File: tb/tb_spi_rx_master.sv
// tb_spi_rx_master: directed checks of the thermocouple SPI master against a converter model.
module tb_spi_rx_master;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_ena = 1'b0;
    logic        miso = 1'b0;
    logic        sclk, cs_n, spi_not_busy, rx_done;
    logic [31:0] spi_rx_data;
    logic [31:0] tx_frame = 32'h0;
    logic [31:0] slave_sr = 32'h0;
    int          rise_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    spi_rx_master #(.CLK_DIV(4), .DATA_BITS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_ena      (spi_ena),
        .miso         (miso),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .spi_not_busy (spi_not_busy),
        .spi_rx_data  (spi_rx_data),
        .rx_done      (rx_done)
    );
    always #5 clk = ~clk;
    always @(negedge cs_n) begin
        slave_sr = tx_frame;
        miso = slave_sr[31];
    end
    always @(negedge sclk) begin
        if (!cs_n) begin
            slave_sr = slave_sr << 1;
            miso = slave_sr[31];
        end
    end
    always @(posedge sclk) if (!cs_n) rise_cnt++;
    task automatic run_frame(input logic [31:0] frame, output int busy, output int dn,
                             output int rises, output logic [31:0] data);
        tx_frame = frame;
        @(negedge clk);
        rise_cnt = 0;
        spi_ena = 1'b1;
        @(negedge clk);
        spi_ena = 1'b0;
        busy = 0;
        dn = 0;
        data = 32'hx;
        for (int i = 0; i < 1000; i++) begin
            if (spi_not_busy) break;
            busy++;
            if (rx_done) begin
                dn++;
                data = spi_rx_data;
            end
            @(negedge clk);
        end
        rises = rise_cnt;
    endtask
    task automatic test_reset;
        int cs_bad = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || sclk !== 1'b0 || spi_not_busy !== 1'b1) cs_bad++;
        end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (spi_not_busy !== 1'b1) begin errors++; $display("FAIL reset_not_busy got %b want 1", spi_not_busy); end
        checks++; if (spi_rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx_data got %h want 0", spi_rx_data); end
        checks++; if (cs_bad !== 0) begin errors++; $display("FAIL reset_idle_stable got %0d bad cycles want 0", cs_bad); end
    endtask
    task automatic test_single_frame;
        int busy, dn, rises;
        logic [31:0] d;
        run_frame(32'h0190_1A40, busy, dn, rises, d);
        checks++; if (busy !== 264) begin errors++; $display("FAIL single_busy got %0d want 264", busy); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL single_rx_done got %0d want 1", dn); end
        checks++; if (rises !== 32) begin errors++; $display("FAIL single_rises got %0d want 32", rises); end
        checks++; if (d !== 32'h0190_1A40) begin errors++; $display("FAIL single_data got %h want 01901a40", d); end
        checks++; if (spi_rx_data !== 32'h0190_1A40) begin errors++; $display("FAIL single_data_held got %h want 01901a40", spi_rx_data); end
    endtask
    task automatic test_bit_order;
        int busy, dn, rises;
        logic [31:0] d;
        run_frame(32'h8000_0001, busy, dn, rises, d);
        checks++; if (spi_rx_data[31] !== 1'b1) begin errors++; $display("FAIL order_msb got %b want 1", spi_rx_data[31]); end
        checks++; if (spi_rx_data[0] !== 1'b1) begin errors++; $display("FAIL order_lsb got %b want 1", spi_rx_data[0]); end
        checks++; if ((spi_rx_data & 32'h7FFF_FFFE) !== 32'h0) begin errors++; $display("FAIL order_middle got %h want 0", spi_rx_data & 32'h7FFF_FFFE); end
    endtask
    task automatic test_stability;
        int busy, dn, rises, changed = 0;
        logic [31:0] d;
        logic got = 1'b0;
        run_frame(32'hAAAA_5555, busy, dn, rises, d);
        checks++; if (spi_rx_data !== 32'hAAAA_5555) begin errors++; $display("FAIL stab_first got %h want aaaa5555", spi_rx_data); end
        tx_frame = 32'h1234_5678;
        spi_ena = 1'b1;
        @(negedge clk);
        spi_ena = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_done) begin
                got = 1'b1;
                d = spi_rx_data;
                break;
            end
            if (spi_rx_data !== 32'hAAAA_5555) changed++;
        end
        checks++; if (changed !== 0) begin errors++; $display("FAIL stab_hold got %0d changed cycles want 0", changed); end
        checks++; if (!got || d !== 32'h1234_5678) begin errors++; $display("FAIL stab_second got %h done %b want 12345678", d, got); end
        repeat (10) @(negedge clk);
    endtask
    task automatic test_back_to_back;
        int nb_high = 0, cs_high = 0;
        logic got = 1'b0;
        logic [31:0] d = 32'h0;
        tx_frame = 32'hC3C3_3C3C;
        @(negedge clk);
        spi_ena = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = rx_done;
        end
        tx_frame = 32'h5A5A_A5A5;
        for (int i = 0; i < 50 && cs_n; i++) begin
            cs_high++;
            if (spi_not_busy) nb_high++;
            @(negedge clk);
        end
        spi_ena = 1'b0;
        checks++; if (nb_high !== 1) begin errors++; $display("FAIL b2b_not_busy got %0d want 1", nb_high); end
        checks++; if (cs_high !== 5) begin errors++; $display("FAIL b2b_cs_high got %0d want 5", cs_high); end
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = rx_done;
            d = spi_rx_data;
        end
        checks++; if (!got || d !== 32'h5A5A_A5A5) begin errors++; $display("FAIL b2b_second got %h done %b want 5a5aa5a5", d, got); end
        repeat (10) @(negedge clk);
    endtask
    task automatic test_reset_mid;
        int busy, dn, rises;
        logic [31:0] d;
        tx_frame = 32'h1357_9BDF;
        @(negedge clk);
        rise_cnt = 0;
        spi_ena = 1'b1;
        @(negedge clk);
        spi_ena = 1'b0;
        for (int i = 0; i < 400 && rise_cnt < 10; i++) @(negedge clk);
        checks++; if (rise_cnt !== 10) begin errors++; $display("FAIL mid_reach got %0d rises want 10", rise_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n got %b want 1", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk got %b want 0", sclk); end
        checks++; if (spi_rx_data !== 32'h0) begin errors++; $display("FAIL mid_rx_data got %h want 0", spi_rx_data); end
        checks++; if (spi_not_busy !== 1'b1) begin errors++; $display("FAIL mid_not_busy got %b want 1", spi_not_busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(32'h0F0F_0F0F, busy, dn, rises, d);
        checks++; if (d !== 32'h0F0F_0F0F) begin errors++; $display("FAIL mid_next_data got %h want 0f0f0f0f", d); end
        checks++; if (rises !== 32) begin errors++; $display("FAIL mid_next_rises got %0d want 32", rises); end
    endtask
    initial begin
        test_reset;
        test_single_frame;
        test_bit_order;
        test_stability;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
